// File: rtl/uart_prog_ctrl_pkg.sv
// uart_prog_pkg: shared states, lane geometry and byte-lane helper for the UART programming controller
package uart_prog_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_e;
  localparam int LANES = 4;
  localparam int LANE_W = $clog2(LANES);
  localparam int DEF_TIMEOUT = 1_000_000;
  function automatic logic [31:0] put_lane(logic [31:0] w, logic [LANE_W-1:0] k, logic [7:0] b);
    put_lane = w;
    put_lane[8*k +: 8] = b;
  endfunction
endpackage

// File: rtl/uart_prog_ctrl_if.sv
// uart_prog_ctrl_if: host byte stream in, memory programming port out
interface uart_prog_ctrl_if #(parameter int ADDR_W = 15);
  logic prog_start;
  logic rx_valid;
  logic [7:0] rx_data;
  logic upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic upg_done_o;
  logic prog_err_o;
  modport master (output prog_start, rx_valid, rx_data, input upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, prog_err_o);
  modport slave (input prog_start, rx_valid, rx_data, output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, prog_err_o);
endinterface

// File: rtl/uart_prog_ctrl_timer.sv
// prog_idle_timer: armed idle counter that flags expiry after TIMEOUT_CYCLES quiet cycles
module prog_idle_timer import uart_prog_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic kick_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic arm_q;
  assign expire_o = en_i && arm_q && !kick_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // Disarm on a new load, restart and arm on every byte, otherwise count quiet cycles while armed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
    end else if (kick_i) begin
      cnt_q <= '0;
      arm_q <= 1'b1;
    end else if (en_i && arm_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/uart_prog_ctrl.sv
// uart_prog_ctrl: packs UART bytes into little-endian words and writes them to program/data memory
module uart_prog_ctrl import uart_prog_pkg::*; #(
  parameter int ADDR_W = 15,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  uart_prog_ctrl_if.slave bus
);
  state_e state_q;
  logic [ADDR_W-1:0] adr_q;
  logic [LANE_W-1:0] cnt_q;
  logic [31:0] word_q, word_d, dat_q;
  logic full_q, err_q, wen_q, done_q;
  logic take, last, expire;
  assign take = state_q == LOAD && bus.rx_valid && !full_q;
  assign last = take && &cnt_q;
  assign word_d = put_lane(word_q, cnt_q, bus.rx_data);
  assign bus.upg_wen_o = wen_q;
  assign bus.upg_adr_o = adr_q;
  assign bus.upg_dat_o = dat_q;
  assign bus.upg_done_o = done_q;
  assign bus.prog_err_o = err_q;
  prog_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE && bus.prog_start),
    .kick_i(state_q == LOAD && bus.rx_valid),
    .en_i(state_q == LOAD),
    .expire_o(expire)
  );
  // Load sequencer: byte packing, word writes, address advance after each write, idle-timeout flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      adr_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      dat_q <= '0;
      full_q <= 1'b0;
      err_q <= 1'b0;
      wen_q <= 1'b0;
      done_q <= 1'b1;
    end else begin
      wen_q <= 1'b0;
      if (wen_q && !full_q) adr_q <= adr_q + 1'b1;
      case (state_q)
        IDLE: if (bus.prog_start) begin
          state_q <= LOAD;
          done_q <= 1'b0;
          adr_q <= '0;
          cnt_q <= '0;
          word_q <= '0;
          full_q <= 1'b0;
          err_q <= 1'b0;
        end
        LOAD: begin
          if (bus.rx_valid && full_q) err_q <= 1'b1;
          if (take) begin
            cnt_q <= cnt_q + 1'b1;
            word_q <= last ? '0 : word_d;
            if (last) begin
              wen_q <= 1'b1;
              dat_q <= word_d;
              full_q <= &adr_q;
            end
          end else if (expire) begin
            state_q <= FLUSH;
            wen_q <= cnt_q != '0 && !full_q;
            dat_q <= word_q;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_prog_ctrl.sv
// tb_uart_prog_ctrl: randomized byte sessions checked against a word-level reference model
module tb_uart_prog_ctrl;
  localparam int AW = 3;
  localparam int TO = 16;
  localparam int CAP = 1 << AW;
  typedef struct {int cyc; int adr; logic [31:0] dat;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  wr_t obs[$];
  wr_t exp_q[$];
  logic [7:0] stim[$];
  int gap[$];
  int n_acc;
  int last;
  logic [31:0] w_acc;

  uart_prog_ctrl_if #(.ADDR_W(AW)) bus();
  uart_prog_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst && bus.upg_wen_o) obs.push_back('{cyc, int'(bus.upg_adr_o), bus.upg_dat_o});

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: byte n of a session lands in word n/4, lane n%4; words beyond capacity are dropped
  task automatic model(logic [7:0] b);
    if (n_acc < 4 * CAP) begin
      w_acc[8 * (n_acc % 4) +: 8] = b;
      if (n_acc % 4 == 3) begin
        exp_q.push_back('{cyc + 1, n_acc / 4, w_acc});
        w_acc = '0;
      end
    end
    n_acc++;
    last = cyc;
  endtask

  task automatic ones();
    gap.delete();
    foreach (stim[i]) gap.push_back(1);
  endtask

  task automatic session();
    int k = 0;
    int idle;
    wr_t o, e;
    n_acc = 0;
    w_acc = '0;
    @(posedge clk); #1 bus.prog_start = 1'b1;
    @(posedge clk); #1 bus.prog_start = 1'b0;
    @(negedge clk) check("done_fall", bus.upg_done_o, 0);
    idle = gap[0];
    while (k < stim.size()) begin
      @(posedge clk); #1;
      if (idle > 1) begin
        bus.rx_valid = 1'b0;
        idle--;
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data = stim[k];
        model(stim[k]);
        k++;
        if (k < stim.size()) idle = gap[k];
      end
    end
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    if (n_acc < 4 * CAP && n_acc % 4 != 0) exp_q.push_back('{last + TO + 1, n_acc / 4, w_acc});
    for (int i = 0; i < TO + 40; i++) begin
      @(negedge clk);
      if (bus.upg_done_o) break;
    end
    check("done_rise", cyc, last + TO + 2);
    repeat (2) @(negedge clk);
    check("err", bus.prog_err_o, n_acc > 4 * CAP);
    check("n_writes", obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      check("wr_cyc", o.cyc, e.cyc);
      check("wr_adr", o.adr, e.adr);
      check("wr_dat", o.dat, e.dat);
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.prog_start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_done", bus.upg_done_o, 1);
    check("rst_wen", bus.upg_wen_o, 0);
    check("rst_err", bus.prog_err_o, 0);
    check("rst_adr", bus.upg_adr_o, 0);
    check("rst_dat", bus.upg_dat_o, 0);
    repeat (5) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'($urandom);
    end
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    repeat (TO + 4) @(negedge clk);
    check("idle_writes", obs.size(), 0);
    check("idle_done", bus.upg_done_o, 1);
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ones();
    session();
    stim.delete();
    repeat (12) stim.push_back(8'($urandom));
    ones();
    session();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    ones();
    session();
    stim.delete();
    repeat (36) stim.push_back(8'($urandom));
    ones();
    session();
    @(posedge clk); #1 bus.prog_start = 1'b1;
    @(posedge clk); #1 bus.prog_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'(8'hA0 + i);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_done", bus.upg_done_o, 1);
    check("arst_wen", bus.upg_wen_o, 0);
    check("arst_adr", bus.upg_adr_o, 0);
    check("arst_dat", bus.upg_dat_o, 0);
    check("arst_err", bus.prog_err_o, 0);
    obs.delete();
    @(posedge clk); #1 rst = 1'b1;
    for (int s = 0; s < 10; s++) begin
      stim.delete();
      gap.delete();
      for (int i = $urandom_range(1, 30); i > 0; i--) begin
        int r;
        stim.push_back(8'($urandom));
        r = $urandom_range(0, 9);
        gap.push_back(gap.size() == 0 ? $urandom_range(1, 40) : r == 0 ? TO : r < 6 ? 1 : $urandom_range(2, TO - 1));
      end
      session();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
